// File: rtl/psg_pkg.sv
// Shared PSG constants: noise tap masks, matching LFSR widths, NF rate encodings and periods.
// Definitions only; no latency, no backpressure.
package psg_pkg;

    localparam int LFSR_BITS_SMS    = 16;
    localparam int LFSR_BITS_SG1000 = 15;
    localparam int LFSR_BITS_TANDY  = 15;

    localparam logic [15:0] TAPS_SMS    = 16'h0009;
    localparam logic [14:0] TAPS_SG1000 = 15'h0003;
    localparam logic [14:0] TAPS_TANDY  = 15'h0011;

    typedef enum logic [1:0] {
        NF_RATE_32   = 2'd0,
        NF_RATE_64   = 2'd1,
        NF_RATE_128  = 2'd2,
        NF_TONE_SYNC = 2'd3
    } nf_e;

    localparam int PERIOD_32  = 32;
    localparam int PERIOD_64  = 64;
    localparam int PERIOD_128 = 128;

    // Smallest counter that can hold PERIOD_128-1.
    localparam int MIN_COUNTER_BITS = 7;

    function automatic int nf_period(input nf_e nf);
        case (nf)
            NF_RATE_32:  return PERIOD_32;
            NF_RATE_64:  return PERIOD_64;
            default:     return PERIOD_128;
        endcase
    endfunction

endpackage

// File: rtl/noise_rate_counter.sv
// Noise rate divider: counts clk_en ticks per NF period, or passes tone_sync through in NF=3.
// shift_req is combinational from the count; no backpressure, cleared by ctrl_we.
module noise_rate_counter
    import psg_pkg::*;
#(
    parameter int COUNTER_BITS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic       ctrl_we,
    input  logic [1:0] nf,
    input  logic       tone_sync,
    output logic       shift_req
);

    generate
        if (COUNTER_BITS < MIN_COUNTER_BITS) begin : g_width_check
            $error("noise_rate_counter: COUNTER_BITS too small to hold 127");
        end
    endgenerate

    nf_e                     nf_mode;
    logic                    tone_mode;
    logic [COUNTER_BITS-1:0] count;
    logic [COUNTER_BITS-1:0] last;

    assign nf_mode   = nf_e'(nf);
    assign tone_mode = (nf_mode == NF_TONE_SYNC);
    assign last      = COUNTER_BITS'(nf_period(nf_mode) - 1);
    assign shift_req = tone_mode ? tone_sync : (clk_en && (count == last));

    // Wrap on terminal count only; a shift never restarts the period by itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (ctrl_we || tone_mode) begin
            count <= '0;
        end else if (clk_en) begin
            count <= (count == last) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/noise_lfsr_gen.sv
// PSG noise channel: programmable-tap LFSR clocked by a rate counter or tone sync; out = lfsr[0].
// Write visible next cycle, shift visible one cycle after its request; no backpressure.
module noise_lfsr_gen
    import psg_pkg::*;
#(
    parameter int                   LFSR_BITS    = 16,
    parameter int                   COUNTER_BITS = 8,
    parameter logic [LFSR_BITS-1:0] SEED         = {1'b1, {(LFSR_BITS-1){1'b0}}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clk_en,
    input  logic                 ctrl_we,
    input  logic [2:0]           ctrl_wdata,
    input  logic [LFSR_BITS-1:0] tap_mask,
    input  logic                 tone_sync,
    output logic                 out,
    output logic                 shift_pulse,
    output logic [LFSR_BITS-1:0] lfsr_state
);

    logic [2:0]           ctrl_q;
    logic [LFSR_BITS-1:0] lfsr;
    logic [LFSR_BITS-1:0] shifted;
    logic [LFSR_BITS-1:0] lfsr_next;
    logic                 fb;
    logic                 shift_req;
    logic                 do_shift;

    noise_rate_counter #(
        .COUNTER_BITS (COUNTER_BITS)
    ) u_rate (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .ctrl_we   (ctrl_we),
        .nf        (ctrl_q[1:0]),
        .tone_sync (tone_sync),
        .shift_req (shift_req)
    );

    // An all-zero result would lock the LFSR, so it is replaced by SEED.
    always_comb begin
        fb        = ctrl_q[2] ? ^(lfsr & tap_mask) : lfsr[0];
        shifted   = {fb, lfsr[LFSR_BITS-1:1]};
        lfsr_next = (shifted == '0) ? SEED : shifted;
    end

    assign do_shift = shift_req && !ctrl_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= 3'b000;
            lfsr        <= SEED;
            shift_pulse <= 1'b0;
        end else begin
            shift_pulse <= do_shift;
            if (ctrl_we) begin
                ctrl_q <= ctrl_wdata;
                lfsr   <= SEED;
            end else if (do_shift) begin
                lfsr <= lfsr_next;
            end
        end
    end

    assign out        = lfsr[0];
    assign lfsr_state = lfsr;

endmodule

// File: tb/tb_noise_lfsr_gen.sv
// Self-checking bench for noise_lfsr_gen: a reference LFSR model fills a scoreboard queue at each
// control write / tone pulse, entries are popped and compared on every observed shift_pulse.
module tb_noise_lfsr_gen;
    import psg_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        ctrl_we;
    logic [2:0]  ctrl_wdata;
    logic [15:0] tap_mask;
    logic        tone_sync;
    logic        out;
    logic        shift_pulse;
    logic [15:0] lfsr_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [15:0] exp_q[$];

    localparam logic [15:0] SEED_V = 16'h8000;

    noise_lfsr_gen #(
        .LFSR_BITS    (16),
        .COUNTER_BITS (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .ctrl_we     (ctrl_we),
        .ctrl_wdata  (ctrl_wdata),
        .tap_mask    (tap_mask),
        .tone_sync   (tone_sync),
        .out         (out),
        .shift_pulse (shift_pulse),
        .lfsr_state  (lfsr_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [15:0] m,
                                               input logic fb_mode);
        logic        f;
        logic [15:0] n;
        f = fb_mode ? ^(s & m) : s[0];
        n = {f, s[15:1]};
        if (n == 16'h0000) n = SEED_V;
        return n;
    endfunction

    task automatic write_ctrl(input logic [2:0] d, output int wc);
        @(negedge clk);
        wc         = cyc;
        ctrl_we    = 1'b1;
        ctrl_wdata = d;
        @(negedge clk);
        ctrl_we    = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output int at, output bit got);
        got = 1'b0;
        at  = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (shift_pulse === 1'b1) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (lfsr_state !== 16'h8000 || out !== 1'b0 || shift_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: lfsr=%h out=%b pulse=%b, want 8000/0/0", lfsr_state, out, shift_pulse);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sms();
        int wc, at, prev;
        bit got;
        logic [15:0] m, e, spot;
        tap_mask = TAPS_SMS;
        clk_en   = 1'b1;
        write_ctrl(3'b100, wc);
        checks++;
        if (lfsr_state !== SEED_V) begin
            failures++;
            $display("FAIL sms_write_seed: lfsr=%h want %h", lfsr_state, SEED_V);
        end
        m = SEED_V;
        for (int i = 1; i <= 16; i++) begin
            m = model_step(m, 16'h0009, 1'b1);
            exp_q.push_back(m);
        end
        prev = wc;
        for (int i = 1; i <= 16; i++) begin
            wait_pulse(40, at, got);
            e = exp_q.pop_front();
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL sms_pulse_timeout: shift %0d not seen, want lfsr %h", i, e);
            end else begin
                if (lfsr_state !== e) begin
                    failures++;
                    $display("FAIL sms_lfsr: shift %0d lfsr=%h want %h", i, lfsr_state, e);
                end
                checks++;
                if ((at - prev) != ((i == 1) ? 33 : 32)) begin
                    failures++;
                    $display("FAIL sms_interval: shift %0d gap=%0d want %0d", i, at - prev, (i == 1) ? 33 : 32);
                end
                if (i == 12 || i == 13 || i == 15 || i == 16) begin
                    case (i)
                        12:      spot = 16'h0008;
                        13:      spot = 16'h8004;
                        15:      spot = 16'h2001;
                        default: spot = 16'h9000;
                    endcase
                    checks++;
                    if (lfsr_state !== spot || out !== spot[0]) begin
                        failures++;
                        $display("FAIL sms_spot: shift %0d lfsr=%h out=%b want %h", i, lfsr_state, out, spot);
                    end
                end
            end
            prev = at;
        end
        // Same data again must still reseed.
        write_ctrl(3'b100, wc);
        checks++;
        if (lfsr_state !== SEED_V || shift_pulse !== 1'b0) begin
            failures++;
            $display("FAIL sms_rewrite_reseed: lfsr=%h pulse=%b want %h/0", lfsr_state, shift_pulse, SEED_V);
        end
    endtask

    task automatic test_periodic();
        int wc, at;
        bit got;
        logic [15:0] m, e;
        logic exp_out;
        clk_en = 1'b1;
        write_ctrl(3'b000, wc);
        m = SEED_V;
        for (int i = 1; i <= 48; i++) begin
            m = model_step(m, tap_mask, 1'b0);
            exp_q.push_back(m);
        end
        for (int i = 1; i <= 48; i++) begin
            wait_pulse(40, at, got);
            e = exp_q.pop_front();
            exp_out = (i == 15 || i == 31 || i == 47);
            checks++;
            if (!got || lfsr_state !== e || out !== exp_out) begin
                failures++;
                $display("FAIL periodic: shift %0d seen=%b lfsr=%h out=%b want %h out=%b", i, got, lfsr_state, out, e, exp_out);
            end
            if ((i % 16) == 0) begin
                checks++;
                if (lfsr_state !== SEED_V) begin
                    failures++;
                    $display("FAIL periodic_wrap: shift %0d lfsr=%h want %h", i, lfsr_state, SEED_V);
                end
            end
        end
    endtask

    task automatic test_rate_gating();
        int wc, ph, hold, np;
        int p[4];
        bit held;
        logic [15:0] m, e;
        clk_en = 1'b0;
        write_ctrl(3'b010, wc);
        m = SEED_V;
        for (int i = 0; i < 4; i++) begin
            m = model_step(m, tap_mask, 1'b0);
            exp_q.push_back(m);
        end
        ph = 0; hold = 0; np = 0; held = 1'b0;
        for (int k = 0; k < 3000 && np < 4; k++) begin
            if (k > 0) @(negedge clk);
            if (shift_pulse === 1'b1) begin
                p[np] = cyc;
                e = exp_q.pop_front();
                checks++;
                if (lfsr_state !== e) begin
                    failures++;
                    $display("FAIL rate_lfsr: pulse %0d lfsr=%h want %h", np, lfsr_state, e);
                end
                np++;
            end
            if (np == 2 && !held && (cyc - p[1]) == 200) begin
                hold = 100;
                held = 1'b1;
            end
            if (hold > 0) begin
                clk_en = 1'b0;
                hold--;
            end else begin
                clk_en = ((ph % 4) == 0);
                ph++;
            end
        end
        clk_en = 1'b0;
        checks++;
        if (np != 4) begin
            failures++;
            $display("FAIL rate_timeout: pulses=%0d want 4", np);
        end else begin
            checks++;
            if ((p[0] - wc) != 510 || (p[1] - p[0]) != 512) begin
                failures++;
                $display("FAIL rate_period: first=%0d gap=%0d want 510/512", p[0] - wc, p[1] - p[0]);
            end
            checks++;
            if ((p[2] - p[1]) != 612 || (p[3] - p[2]) != 512) begin
                failures++;
                $display("FAIL rate_gating: gaps=%0d/%0d want 612/512", p[2] - p[1], p[3] - p[2]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_tone_sync();
        int wc, npulse;
        logic [15:0] m, e;
        clk_en = 1'b1;
        write_ctrl(3'b011, wc);
        npulse = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (shift_pulse === 1'b1) npulse++;
        end
        checks++;
        if (npulse != 0) begin
            failures++;
            $display("FAIL tone_no_count: pulses=%0d want 0", npulse);
        end
        m = SEED_V;
        for (int i = 0; i < 4; i++) begin
            clk_en    = i[0];
            tone_sync = 1'b1;
            m = model_step(m, tap_mask, 1'b0);
            exp_q.push_back(m);
            @(negedge clk);
            tone_sync = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (shift_pulse !== 1'b1 || lfsr_state !== e) begin
                failures++;
                $display("FAIL tone_shift: pulse %0d pulse=%b lfsr=%h want 1/%h", i, shift_pulse, lfsr_state, e);
            end
            @(negedge clk);
            checks++;
            if (shift_pulse !== 1'b0) begin
                failures++;
                $display("FAIL tone_pulse_width: pulse %0d still high", i);
            end
        end
        ctrl_we    = 1'b1;
        ctrl_wdata = 3'b111;
        tone_sync  = 1'b1;
        @(negedge clk);
        ctrl_we   = 1'b0;
        tone_sync = 1'b0;
        checks++;
        if (lfsr_state !== SEED_V || shift_pulse !== 1'b0) begin
            failures++;
            $display("FAIL tone_collision: lfsr=%h pulse=%b want %h/0", lfsr_state, shift_pulse, SEED_V);
        end
        tone_sync = 1'b1;
        exp_q.push_back(model_step(SEED_V, tap_mask, 1'b1));
        @(negedge clk);
        tone_sync = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (shift_pulse !== 1'b1 || lfsr_state !== e) begin
            failures++;
            $display("FAIL tone_white: pulse=%b lfsr=%h want 1/%h", shift_pulse, lfsr_state, e);
        end
    endtask

    task automatic test_lockup();
        int wc, at;
        bit got;
        logic [15:0] m, e;
        tap_mask = 16'h0000;
        clk_en   = 1'b1;
        write_ctrl(3'b100, wc);
        m = SEED_V;
        for (int i = 1; i <= 17; i++) begin
            m = model_step(m, 16'h0000, 1'b1);
            exp_q.push_back(m);
        end
        for (int i = 1; i <= 17; i++) begin
            wait_pulse(40, at, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || lfsr_state !== e) begin
                failures++;
                $display("FAIL lockup: shift %0d seen=%b lfsr=%h want %h", i, got, lfsr_state, e);
            end
            if (i == 15 || i == 16) begin
                checks++;
                if (lfsr_state !== ((i == 15) ? 16'h0001 : 16'h8000)) begin
                    failures++;
                    $display("FAIL lockup_spot: shift %0d lfsr=%h want %h", i, lfsr_state, (i == 15) ? 16'h0001 : 16'h8000);
                end
            end
        end
        tap_mask = TAPS_SMS;
    endtask

    task automatic test_reset_mid();
        int wc, at, rc;
        bit got;
        logic [15:0] e;
        clk_en = 1'b1;
        write_ctrl(3'b100, wc);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(40, at, got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL mid_pre_pulse: pulse %0d not seen", i);
            end
        end
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (lfsr_state !== 16'h8000 || out !== 1'b0 || shift_pulse !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_async: lfsr=%h out=%b pulse=%b want 8000/0/0", lfsr_state, out, shift_pulse);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rc = cyc;
        exp_q.push_back(model_step(SEED_V, tap_mask, 1'b0));
        wait_pulse(40, at, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || (at - rc) != 32 || lfsr_state !== e) begin
            failures++;
            $display("FAIL mid_release: seen=%b delay=%0d lfsr=%h want 32/%h", got, at - rc, lfsr_state, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        clk_en     = 1'b0;
        ctrl_we    = 1'b0;
        ctrl_wdata = 3'b000;
        tap_mask   = TAPS_SMS;
        tone_sync  = 1'b0;
        test_reset();
        test_sms();
        test_periodic();
        test_rate_gating();
        test_tone_sync();
        test_lockup();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
